// File: rtl/delay_timer_arbiter.sv
// Shared tick-driven delay timer: round-robin arbitration among N_REQ requesters,
// duration latched at grant, one-cycle done pulse to the owner on expiry.
module delay_timer_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 13
) (
    input  logic                   clk_50M,
    input  logic                   i_Reset,
    input  logic                   i_Tick,
    input  logic [N_REQ-1:0]       i_Req,
    input  logic [N_REQ*CNT_W-1:0] i_Dur,
    input  logic                   i_Abort,
    output logic [N_REQ-1:0]       o_Grant,
    output logic [N_REQ-1:0]       o_Done,
    output logic                   o_Busy,
    output logic [CNT_W-1:0]       o_Remaining
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned IDX_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]   r_owner, w_owner_nxt;
    logic [PTR_W-1:0]   w_owner_inc;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [N_REQ-1:0]   r_done, w_done_nxt;
    logic [CNT_W-1:0]   r_rem, w_rem_nxt;
    logic               r_busy;
    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_idx;
    logic [CNT_W-1:0]   w_dur_sel;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + IDX_W'(i);
            if (w_idx >= IDX_W'(N_REQ)) begin
                w_idx = w_idx - IDX_W'(N_REQ);
            end
            w_cand = w_idx[PTR_W-1:0];
            if (!w_found && i_Req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_dur_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_sel == PTR_W'(k)) begin
                w_dur_sel = i_Dur[k*CNT_W +: CNT_W];
            end
        end
    end

    assign w_owner_inc = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_rem_nxt   = r_rem;
        unique case (r_state)
            StIdle: begin
                if (w_found) begin
                    // A zero duration still spends its grant cycle in RUN, expiring next edge.
                    w_state_nxt = StRun;
                    w_owner_nxt = w_sel;
                    w_grant_nxt = N_REQ'(1) << w_sel;
                    w_rem_nxt   = w_dur_sel;
                end
            end
            StRun: begin
                if (i_Abort || !i_Req[r_owner]) begin
                    w_state_nxt = StIdle;
                    w_grant_nxt = '0;
                    w_rem_nxt   = '0;
                    w_ptr_nxt   = w_owner_inc;
                end else if (r_rem == '0) begin
                    w_state_nxt = StDone;
                    w_done_nxt  = r_grant;
                end else if (i_Tick) begin
                    w_rem_nxt = r_rem - CNT_W'(1);
                    if (r_rem == CNT_W'(1)) begin
                        w_state_nxt = StDone;
                        w_done_nxt  = r_grant;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_grant_nxt = '0;
                w_ptr_nxt   = w_owner_inc;
            end
            default: begin
                w_state_nxt = StIdle;
                w_grant_nxt = '0;
                w_rem_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50M or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_rem   <= w_rem_nxt;
            r_busy  <= (w_state_nxt != StIdle);
        end
    end

    assign o_Grant     = r_grant;
    assign o_Done      = r_done;
    assign o_Busy      = r_busy;
    assign o_Remaining = r_rem;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter: directed sequences, a vector table, and random
// stimulus checked against a transaction-level reference model.
module tb_delay_timer_arbiter;

    localparam int N = 4;
    localparam int W = 13;

    logic           clk_50M = 1'b0;
    logic           i_Reset;
    logic           i_Tick;
    logic [N-1:0]   i_Req;
    logic [N*W-1:0] i_Dur;
    logic           i_Abort;
    logic [N-1:0]   o_Grant;
    logic [N-1:0]   o_Done;
    logic           o_Busy;
    logic [W-1:0]   o_Remaining;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt[N];
    bit mon_en  = 1'b0;

    delay_timer_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk_50M     (clk_50M),
        .i_Reset     (i_Reset),
        .i_Tick      (i_Tick),
        .i_Req       (i_Req),
        .i_Dur       (i_Dur),
        .i_Abort     (i_Abort),
        .o_Grant     (o_Grant),
        .o_Done      (o_Done),
        .o_Busy      (o_Busy),
        .o_Remaining (o_Remaining)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_50M) begin
        if (mon_en && !i_Reset) begin
            check("onehot0_grant", 32'($onehot0(o_Grant)), 32'd1);
            check("onehot0_done", 32'($onehot0(o_Done)), 32'd1);
            for (int k = 0; k < N; k++) begin
                if (o_Done[k]) done_cnt[k]++;
            end
        end
    end

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        i_Req   = '0;
        i_Abort = 1'b0;
        i_Tick  = 1'b0;
        step();
        step();
        i_Reset = 1'b0;
    endtask

    function automatic logic [31:0] pack_out();
        return 32'({o_Grant, o_Done, o_Busy, o_Remaining});
    endfunction

    // Reference model: owner index (-1 = idle), ticks left, pending done, rr pointer.
    int m_owner, m_left, m_ptr;
    bit m_done;

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_ptr   = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] req, input logic [N*W-1:0] dur,
                              input logic abort, input logic tick);
        bit found;
        int c;
        if (m_done) begin
            m_done  = 1'b0;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_left  = int'(dur[c*W +: W]);
                end
            end
        end else if (abort || !req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_left  = 0;
        end else if (m_left == 0) begin
            m_done = 1'b1;
        end else if (tick) begin
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_out();
        logic [N-1:0] g;
        logic [N-1:0] d;
        g = '0;
        d = '0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            if (m_done) d[m_owner] = 1'b1;
        end
        return 32'({g, d, (m_owner >= 0), W'(m_left)});
    endfunction

    typedef struct {
        logic [N-1:0] req;
        logic         abort;
        logic         tick;
        logic [N-1:0] grant;
        logic [N-1:0] done;
        logic         busy;
        logic [W-1:0] rem;
    } vec_t;

    vec_t vecs[15];
    int   busy_cnt;
    logic [N-1:0] exp_g;

    initial begin
        // Durations for the table: slice3=3, slice2=0, slice1=1, slice0=2.
        vecs[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 13'd0};
        vecs[1]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 13'd1};
        vecs[2]  = '{4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 13'd1};
        vecs[3]  = '{4'b0010, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 13'd0};
        vecs[4]  = '{4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 13'd0};
        vecs[5]  = '{4'b0011, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 13'd2};
        vecs[6]  = '{4'b0011, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 13'd0};
        vecs[7]  = '{4'b0111, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 13'd1};
        vecs[8]  = '{4'b0111, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 13'd0};
        vecs[9]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 13'd0};
        vecs[10] = '{4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 13'd0};
        vecs[11] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 13'd0};
        vecs[12] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b1, 13'd3};
        vecs[13] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 4'b0000, 1'b1, 13'd2};
        vecs[14] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 13'd0};

        for (int k = 0; k < N; k++) done_cnt[k] = 0;
        i_Dur = '0;
        do_reset();
        check("reset_state", pack_out(), 32'd0);
        mon_en = 1'b1;

        // T1: async reset mid-RUN
        i_Dur[0*W +: W] = 13'd1234;
        i_Req = 4'b0001;
        step();
        check("t1_run", pack_out(), 32'({4'b0001, 4'b0000, 1'b1, 13'd1234}));
        #3 i_Reset = 1'b1;
        #1 check("t1_async", pack_out(), 32'd0);
        step();
        i_Reset = 1'b0;
        step();
        check("t1_regrant", 32'(o_Grant), 32'(4'b0001));

        // T2: single timing with spaced ticks
        do_reset();
        i_Dur = {13'd9, 13'd9, 13'd3, 13'd9};
        i_Req = 4'b0010;
        step();
        check("t2_grant", pack_out(), 32'({4'b0010, 4'b0000, 1'b1, 13'd3}));
        for (int t = 1; t <= 3; t++) begin
            i_Tick = 1'b0;
            repeat (19) step();
            i_Tick = 1'b1;
            step();
            i_Tick = 1'b0;
            if (t < 3) check("t2_count", pack_out(), 32'({4'b0010, 4'b0000, 1'b1, W'(3 - t)}));
        end
        check("t2_done", pack_out(), 32'({4'b0010, 4'b0010, 1'b1, 13'd0}));
        i_Req = 4'b0000;
        step();
        check("t2_idle", pack_out(), 32'd0);

        // T3: round-robin with all requesters held
        do_reset();
        i_Dur = {13'd2, 13'd2, 13'd2, 13'd2};
        for (int k = 0; k < N; k++) done_cnt[k] = 0;
        i_Req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            exp_g = 4'b0001 << (s % N);
            i_Tick = 1'b0;
            step();
            check("t3_grant", 32'(o_Grant), 32'(exp_g));
            i_Tick = 1'b1;
            step();
            step();
            check("t3_done", 32'(o_Done), 32'(exp_g));
            i_Tick = 1'b0;
            step();
            check("t3_release", 32'(o_Grant), 32'd0);
            if (s == 3) begin
                for (int k = 0; k < N; k++) check("t3_done_once", 32'(done_cnt[k]), 32'd1);
            end
        end
        i_Req = 4'b0000;

        // T4: zero duration
        do_reset();
        i_Dur = {13'd5, 13'd0, 13'd5, 13'd5};
        i_Req = 4'b0100;
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            busy_cnt += int'(o_Busy);
            if (i == 0) check("t4_grant", 32'({o_Grant, o_Done}), 32'({4'b0100, 4'b0000}));
            if (i == 1) begin
                check("t4_done", 32'(o_Done), 32'(4'b0100));
                i_Req = 4'b0000;
            end
        end
        check("t4_busy_cycles", 32'(busy_cnt), 32'd2);

        // T5: cancel by dropping the request, pending requester served next
        do_reset();
        i_Dur = {13'd7, 13'd7, 13'd7, 13'd4000};
        for (int k = 0; k < N; k++) done_cnt[k] = 0;
        i_Req = 4'b1001;
        step();
        check("t5_grant", pack_out(), 32'({4'b0001, 4'b0000, 1'b1, 13'd4000}));
        repeat (10) begin
            i_Tick = 1'b1;
            step();
            i_Tick = 1'b0;
            step();
            step();
        end
        check("t5_rem", 32'(o_Remaining), 32'd3990);
        i_Req = 4'b1000;
        step();
        check("t5_cancel", pack_out(), 32'd0);
        step();
        check("t5_next", 32'(o_Grant), 32'(4'b1000));
        check("t5_no_done", 32'(done_cnt[0]), 32'd0);
        i_Req = 4'b0000;

        // Vector table (includes abort vs expiring tick, abort in DONE)
        do_reset();
        i_Dur = {13'd3, 13'd0, 13'd1, 13'd2};
        foreach (vecs[v]) begin
            i_Req   = vecs[v].req;
            i_Abort = vecs[v].abort;
            i_Tick  = vecs[v].tick;
            step();
            check($sformatf("vec%0d", v), pack_out(),
                  32'({vecs[v].grant, vecs[v].done, vecs[v].busy, vecs[v].rem}));
        end
        i_Abort = 1'b0;
        i_Tick  = 1'b0;

        // Random stimulus against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 9) == 0) i_Req[k] = ~i_Req[k];
                if ($urandom_range(0, 3) == 0) i_Dur[k*W +: W] = W'($urandom_range(0, 6));
            end
            i_Abort = ($urandom_range(0, 15) == 0);
            i_Tick  = ($urandom_range(0, 2) == 0);
            model_edge(i_Req, i_Dur, i_Abort, i_Tick);
            step();
            check("rand", pack_out(), model_out());
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
